// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit
// common-anode seven-segment display.
//
// Each digit gets a SHOW slot of CLK_DIV cycles. During the slot its anode
// is driven and its BCD code and decimal point go to the shared decoder.
// A BLANK gap of BLANK_CYCLES cycles with all anodes off follows each slot.
//
// New values are captured into a pending buffer. They are copied into the
// shadow (displayed) buffer only at the frame boundary, so a frame never
// shows a mix of old and new digits.
//
// Optional build macro: SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 8,
   parameter int CLK_DIV      = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   output logic [3:0]              digit_code,
   output logic                    dp_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic                    load_ack,
   output logic                    frame_done
);

   localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [IDX_W-1:0]        idx;

   logic [4*NUM_DIGITS-1:0] shadow_bcd;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [4*NUM_DIGITS-1:0] pend_bcd;
   logic [NUM_DIGITS-1:0]   pend_dp;
   logic                    pending;

   logic                    show_end;
   logic                    blank_end;
   logic                    boundary;
   logic                    commit_load;
   logic                    commit_pend;
   logic [IDX_W-1:0]        idx_adv;
   logic [4*NUM_DIGITS-1:0] shadow_bcd_nxt;
   logic [NUM_DIGITS-1:0]   shadow_dp_nxt;
   logic [3:0]              sel_code;
   logic                    sel_dp;
   logic [NUM_DIGITS-1:0]   an_sel;
   logic                    blank_slot;

   // Slot terminal counts, frame boundary and the commit source for the shadow buffer
   always_comb begin
      show_end    = (state == SHOW)  && (cnt == SHOW_LAST);
      blank_end   = (state == BLANK) && (cnt == BLANK_LAST);
      idx_adv     = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      boundary    = blank_end && (idx == IDX_LAST);
      // A load landing on the boundary itself bypasses the pending buffer
      // and overrides whatever was pending.
      commit_load = boundary && load;
      commit_pend = boundary && pending && !load;
      if (commit_load) begin
         shadow_bcd_nxt = bcd_in;
         shadow_dp_nxt  = dp_in;
      end else if (commit_pend) begin
         shadow_bcd_nxt = pend_bcd;
         shadow_dp_nxt  = pend_dp;
      end else begin
         shadow_bcd_nxt = shadow_bcd;
         shadow_dp_nxt  = shadow_dp;
      end
   end

   // Select the code and decimal point of the digit whose SHOW slot starts next
   always_comb begin
      sel_code = '0;
      sel_dp   = 1'b0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         if (idx_adv == IDX_W'(k)) begin
            sel_code = shadow_bcd_nxt[4*k +: 4];
            sel_dp   = shadow_dp_nxt[k];
         end
      end
      an_sel = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_adv);
   end

`ifdef SEG_SCAN_LZB_EN
   logic [NUM_DIGITS-1:0] lead_zero;
   logic                  lz_run;

   // Mark each digit that sits inside the run of all-zero, no-dp digits from the left
   always_comb begin
      lz_run    = 1'b1;
      lead_zero = '0;
      for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
         lz_run = lz_run
                & (shadow_bcd_nxt[4*(NUM_DIGITS-1-j) +: 4] == 4'd0)
                & ~shadow_dp_nxt[NUM_DIGITS-1-j];
         lead_zero[NUM_DIGITS-1-j] = lz_run;
      end
      blank_slot = lead_zero[idx_adv] && (idx_adv != '0);
   end
`else
   // All digits are always driven
   always_comb begin
      blank_slot = 1'b0;
   end
`endif

   // Scan FSM, load buffering and registered display outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BLANK;
         cnt        <= '0;
         idx        <= IDX_LAST;
         shadow_bcd <= '0;
         shadow_dp  <= '0;
         pend_bcd   <= '0;
         pend_dp    <= '0;
         pending    <= 1'b0;
         an_n       <= '1;
         digit_code <= '0;
         dp_n       <= 1'b1;
         load_ack   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         load_ack   <= 1'b0;
         frame_done <= 1'b0;

         if (boundary) begin
            shadow_bcd <= shadow_bcd_nxt;
            shadow_dp  <= shadow_dp_nxt;
            pending    <= 1'b0;
            if (commit_load || commit_pend) begin
               load_ack <= 1'b1;
            end
         end else if (load) begin
            pend_bcd <= bcd_in;
            pend_dp  <= dp_in;
            pending  <= 1'b1;
         end

         case (state)
            SHOW: begin
               if (show_end) begin
                  state <= BLANK;
                  cnt   <= '0;
                  an_n  <= '1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            BLANK: begin
               if (blank_end) begin
                  state      <= SHOW;
                  cnt        <= '0;
                  idx        <= idx_adv;
                  an_n       <= blank_slot ? '1 : an_sel;
                  digit_code <= sel_code;
                  dp_n       <= ~sel_dp;
                  if (idx == IDX_LAST) begin
                     frame_done <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= BLANK;
               cnt   <= '0;
               an_n  <= '1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, CLK_DIV=4, BLANK_CYCLES=1.
// A frame is 20 cycles, and boundaries fall at cycles 1, 21, 41, ... after reset release.
// Expected SHOW slots are queued per frame and consumed by the slot monitor.
module tb_seg_scan_ctrl;

   localparam int N  = 4;
   localparam int CD = 4;
   localparam int BC = 1;
`ifdef SEG_SCAN_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load;
   logic [4*N-1:0] bcd_in;
   logic [N-1:0]  dp_in;
   logic [3:0]    digit_code;
   logic          dp_n;
   logic [N-1:0]  an_n;
   logic          load_ack;
   logic          frame_done;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .NUM_DIGITS   (N),
      .CLK_DIV      (CD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .bcd_in     (bcd_in),
      .dp_in      (dp_in),
      .digit_code (digit_code),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .load_ack   (load_ack),
      .frame_done (frame_done)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [3:0] code;
      logic       dp;
   } slot_t;

   slot_t      sbq[$];
   slot_t      cur;
   int         tests = 0;
   int         fails = 0;
   int         cyc;
   bit         mon_en = 1'b0;
   logic [3:0] prev_an = 4'hF;

   // Cycles since reset release
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Queue the lit slots of one frame, digit 0 first, applying leading-zero blanking when built in
   task automatic push_frame(input logic [15:0] b, input logic [3:0] d);
      bit         run;
      bit         lit [N];
      slot_t      s;
      logic [3:0] one;
      run = 1'b1;
      for (int k = N - 1; k >= 0; k--) begin
         run    = run && (b[4*k +: 4] == 4'd0) && !d[k];
         lit[k] = !(LZB && run && k != 0);
      end
      for (int k = 0; k < N; k++) begin
         if (lit[k]) begin
            one    = 4'b0001 << k;
            s.an   = ~one;
            s.code = b[4*k +: 4];
            s.dp   = ~d[k];
            sbq.push_back(s);
         end
      end
   endtask

   // Slot monitor: pops an expected slot when an anode turns on and holds it while lit
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         chk("an_onehot", 32'($countones(~an_n) <= 1), 32'd1);
         if (an_n != 4'hF) begin
            if (prev_an == 4'hF) begin
               chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
               if (sbq.size() != 0) cur = sbq.pop_front();
            end
            chk("slot_an",   32'(an_n),       32'(cur.an));
            chk("slot_code", 32'(digit_code), 32'(cur.code));
            chk("slot_dp_n", 32'(dp_n),       32'(cur.dp));
         end
         prev_an = an_n;
      end else begin
         prev_an = 4'hF;
      end
   end

   task automatic run_to(input int n, input int ack_at);
      while (cyc < n) begin
         @(negedge clk);
         chk("load_ack",   32'(load_ack),   32'(cyc == ack_at));
         chk("frame_done", 32'(frame_done), 32'((cyc % 20) == 1));
      end
   endtask

   task automatic load_pulse(input logic [15:0] b, input logic [3:0] d);
      load   = 1'b1;
      bcd_in = b;
      dp_in  = d;
      @(negedge clk);
      load   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int         pos;
      int         slot;
      bit         lit;
      logic [3:0] one;
      logic [3:0] exp_an;

      rst_n  = 1'b0;
      load   = 1'b0;
      bcd_in = '0;
      dp_in  = '0;
      repeat (3) @(negedge clk);
      chk("rst_an_n",       32'(an_n),       32'hF);
      chk("rst_digit_code", 32'(digit_code), 32'h0);
      chk("rst_dp_n",       32'(dp_n),       32'h1);
      chk("rst_load_ack",   32'(load_ack),   32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);

      // Scan timing from reset release over two frames
      push_frame(16'h0000, 4'b0000);
      push_frame(16'h0000, 4'b0000);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      chk("first_blank_an", 32'(an_n), 32'hF);
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         pos    = (c - 1) % 5;
         slot   = ((c - 1) / 5) % 4;
         lit    = (pos < 4) && (!LZB || slot == 0);
         one    = 4'b0001 << slot;
         exp_an = lit ? ~one : 4'hF;
         chk("t1_an_n",       32'(an_n),       32'(exp_an));
         chk("t1_frame_done", 32'(frame_done), 32'((c % 20) == 1));
         chk("t1_load_ack",   32'(load_ack),   32'h0);
      end

      // Mid-frame load waits for the next boundary
      push_frame(16'h0000, 4'b0000);
      run_to(45, -1);
      load_pulse(16'h1234, 4'b0100);
      push_frame(16'h1234, 4'b0100);
      run_to(63, 61);

      // Two loads in one frame: the latest wins, one ack
      load_pulse(16'h1111, 4'b0000);
      run_to(70, -1);
      load_pulse(16'h5678, 4'b0000);
      push_frame(16'h5678, 4'b0000);
      run_to(85, 81);

      // Load on the boundary cycle overrides an older pending value
      load_pulse(16'h1111, 4'b0000);
      push_frame(16'h9999, 4'b0000);
      run_to(100, -1);
      load_pulse(16'h9999, 4'b0000);
      chk("t4_load_ack",   32'(load_ack),   32'h1);
      chk("t4_frame_done", 32'(frame_done), 32'h1);
      push_frame(16'h9999, 4'b0000);
      run_to(125, -1);

      // Asynchronous reset in the middle of digit 2's SHOW slot, with a load pending
      load_pulse(16'h4321, 4'b1111);
      run_to(132, -1);
      #2;
      mon_en = 1'b0;
      chk("t5_sb_left", 32'(sbq.size()), 32'd1);
      chk("t5_pre_code", 32'(digit_code), 32'h9);
      rst_n = 1'b0;
      #1;
      chk("t5_an_n",       32'(an_n),       32'hF);
      chk("t5_dp_n",       32'(dp_n),       32'h1);
      chk("t5_digit_code", 32'(digit_code), 32'h0);
      chk("t5_frame_done", 32'(frame_done), 32'h0);
      sbq.delete();
      repeat (2) @(negedge clk);
      push_frame(16'h0000, 4'b0000);
      push_frame(16'h0000, 4'b0000);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      chk("t5_release_an", 32'(an_n), 32'hF);
      run_to(30, -1);

      // Leading zeros, then an all-zero value whose top digit carries a dp
      load_pulse(16'h0042, 4'b0000);
      push_frame(16'h0042, 4'b0000);
      run_to(50, 41);
      load_pulse(16'h0000, 4'b1000);
      push_frame(16'h0000, 4'b1000);
      run_to(80, 61);
      mon_en = 1'b0;
      chk("end_sb_left", 32'(sbq.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
